// File: rtl/accumulator_tx_serializer_pkg.sv
// Shared definitions for the accumulator TX serializer: FSM state encoding
// and the counter-width helper used by the top and the bit-period counter.
// Optional feature macro: PARITY_BIT_EN (adds an even-parity bit after DATA).
package accumulator_tx_serializer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef PARITY_BIT_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_e;

    // Counter width for a modulus of n; a modulus of 1 still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/accumulator_tx_serializer_bit_period_counter.sv
// Bit-period counter: counts 0..Clocks_Per_Bit-1 while enabled and flags the
// last cycle of each serial bit. Held at zero while disabled so every frame
// starts with a full-length first bit.
module accumulator_tx_serializer_bit_period_counter
    import accumulator_tx_serializer_pkg::*;
#(
    parameter int unsigned Clocks_Per_Bit = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = cnt_width(Clocks_Per_Bit);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(Clocks_Per_Bit - 32'd1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear when idle, wrap at the end of the bit, else increment.
    always_comb begin
        count_d = count_q;
        if (!en_i) begin
            count_d = '0;
        end else if (count_q == LAST) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = (count_q == LAST);

endmodule

// File: rtl/accumulator_tx_serializer.sv
// Accumulator TX serializer: captures a parallel word on Load and sends it as
// start bit, data bits LSB first, optional even parity, and stop bit, each
// held Clocks_Per_Bit cycles. All outputs are registered.
// Optional feature macro: PARITY_BIT_EN.
module accumulator_tx_serializer
    import accumulator_tx_serializer_pkg::*;
#(
    parameter int unsigned Word_Length    = 8,
    parameter int unsigned Clocks_Per_Bit = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Load,
    input  logic [Word_Length-1:0] Data_Input,
    output logic                   Serial_Out,
    output logic                   Busy,
    output logic                   Done
);

    localparam int unsigned BIT_W = cnt_width(Word_Length);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(Word_Length - 32'd1);

    tx_state_e              state_q, state_d;
    logic [Word_Length-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]       bit_idx_q, bit_idx_d;
    logic                   serial_q, serial_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   bit_tick_s;

    accumulator_tx_serializer_bit_period_counter #(
        .Clocks_Per_Bit(Clocks_Per_Bit)
    ) u_bit_period_counter (
        .clk_i   (clk),
        .reset_i (reset),
        .en_i    (state_q != ST_IDLE),
        .tick_o  (bit_tick_s)
    );

    // Next-state, shift register and registered-output decode.
    // The shift register rotates rather than shifts, so after the last data
    // bit it again holds the captured word (used for parity).
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Load) begin
                    state_d   = ST_START;
                    shreg_d   = Data_Input;
                    bit_idx_d = '0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_tick_s) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end else begin
                    state_d   = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_tick_s) begin
                    shreg_d = {shreg_q[0], shreg_q[Word_Length-1:1]};
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d = '0;
`ifdef PARITY_BIT_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef PARITY_BIT_EN
            ST_PARITY: begin
                if (bit_tick_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (bit_tick_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                shreg_d   = '0;
                bit_idx_d = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_IDLE:   serial_d = 1'b1;
            ST_START:  serial_d = 1'b0;
            ST_DATA:   serial_d = shreg_d[0];
`ifdef PARITY_BIT_EN
            ST_PARITY: serial_d = ^shreg_d;
`endif
            ST_STOP:   serial_d = 1'b1;
            default:   serial_d = 1'b1;
        endcase
    end

    // State, data path and output registers; reset aborts any frame at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            serial_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            serial_q  <= serial_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign Serial_Out = serial_q;
    assign Busy       = busy_q;
    assign Done       = done_q;

endmodule

// File: tb/tb_accumulator_tx_serializer.sv
// Self-checking bench for accumulator_tx_serializer. Expected line levels are
// derived from the frame format: bit j of a frame is start (0), data LSB
// first, optional even parity, stop (1), each lasting CPB cycles.
module tb_accumulator_tx_serializer;

    localparam int WL  = 8;
    localparam int CPB = 4;
`ifdef PARITY_BIT_EN
    localparam int NBITS = WL + 3;
`else
    localparam int NBITS = WL + 2;
`endif
    localparam int FL = NBITS * CPB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          Load = 1'b0;
    logic [WL-1:0] Data_Input = '0;
    logic          Serial_Out;
    logic          Busy;
    logic          Done;

    int compared = 0;
    int mismatched = 0;

    accumulator_tx_serializer #(
        .Word_Length    (WL),
        .Clocks_Per_Bit (CPB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Load       (Load),
        .Data_Input (Data_Input),
        .Serial_Out (Serial_Out),
        .Busy       (Busy),
        .Done       (Done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [WL-1:0] d, input int j);
        if (j == 0) return 1'b0;
        if (j <= WL) return d[j-1];
`ifdef PARITY_BIT_EN
        if (j == WL + 1) return logic'($countones(d) % 2);
`endif
        return 1'b1;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_serial"}, Serial_Out, 1'b1);
        chk({tag, "_busy"}, Busy, 1'b0);
        chk({tag, "_done"}, Done, 1'b0);
    endtask

    // Runs one frame: Load is sampled at the next edge. hold keeps Load high
    // (Data_Input switches to d_next); disturb >= 0 pulses Load with 8'hFF at
    // that frame cycle. Ends in the Done cycle.
    task automatic run_frame(input logic [WL-1:0] d, input bit hold,
                             input logic [WL-1:0] d_next, input int disturb);
        Load = 1'b1;
        Data_Input = d;
        step();
        if (hold) Data_Input = d_next;
        else Load = 1'b0;
        for (int k = 0; k < FL; k++) begin
            chk($sformatf("serial_c%0d", k), Serial_Out, frame_bit(d, k / CPB));
            chk($sformatf("busy_c%0d", k), Busy, 1'b1);
            chk($sformatf("done_c%0d", k), Done, 1'b0);
            if (disturb >= 0 && k == disturb) begin
                Load = 1'b1;
                Data_Input = 8'hFF;
            end else if (disturb >= 0 && k == disturb + 1) begin
                Load = 1'b0;
            end
            step();
        end
        chk("done_pulse", Done, 1'b1);
        chk("done_busy", Busy, 1'b0);
        chk("done_serial", Serial_Out, 1'b1);
    endtask

    initial begin
        // Reset held two cycles, then released.
        for (int i = 0; i < 2; i++) begin
            step();
            check_idle("reset");
        end
        reset = 1'b0;
        step();
        check_idle("post_reset");

        // Directed 8'h03 frame.
        run_frame(8'h03, 1'b0, 8'h00, -1);
        step();
        check_idle("after_03");

        // Load pulse and data change mid-frame are ignored.
        run_frame(8'h03, 1'b0, 8'h00, 10);
        for (int i = 0; i < 6; i++) begin
            step();
            check_idle("no_second_frame");
        end

        // Load held: two back-to-back frames, then a third is stopped.
        run_frame(8'hA5, 1'b1, 8'h5A, -1);
        run_frame(8'h5A, 1'b0, 8'h00, -1);
        step();
        check_idle("after_b2b");

        // Random frames with random gaps (gap 0 is back-to-back from Done).
        for (int n = 0; n < 8; n++) begin
            logic [WL-1:0] rd;
            int gap;
            rd = WL'($urandom);
            gap = $urandom_range(0, 3);
            run_frame(rd, 1'b0, 8'h00, -1);
            for (int g = 0; g < gap; g++) begin
                step();
                check_idle("rand_gap");
            end
        end
        step();
        check_idle("after_rand");

        // Reset at frame cycle 20 aborts with no Done.
        Load = 1'b1;
        Data_Input = 8'h3C;
        step();
        Load = 1'b0;
        for (int k = 0; k < 20; k++) step();
        chk("pre_abort_busy", Busy, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_serial", Serial_Out, 1'b1);
        chk("abort_busy", Busy, 1'b0);
        chk("abort_done", Done, 1'b0);
        for (int i = 0; i < FL; i++) begin
            step();
            check_idle("after_abort");
        end

        // Reset wins over Load in the same cycle.
        reset = 1'b1;
        Load = 1'b1;
        Data_Input = 8'h81;
        step();
        check_idle("reset_vs_load");
        reset = 1'b0;
        Load = 1'b0;
        step();
        check_idle("reset_vs_load_after");

        // A plain frame still works afterwards.
        run_frame(8'h81, 1'b0, 8'h00, -1);
        step();
        check_idle("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
